// File: rtl/count_pkg.sv
// Shared defaults, op encoding and pointer helper
// for the round-robin count arbiter.
package count_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 32;
  localparam int PTR_W     = 3;

  localparam logic OP_INC = 1'b0;
  localparam logic OP_DEC = 1'b1;

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p,
    input int               n
  );
    if (int'(p) >= n - 1) return '0;
    return p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: rotate pend by ptr,
// find first set bit, rotate the index back.
module rr_pick
  import count_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]  pend_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  win_oh_o,
  output logic [PTR_W-1:0] win_idx_o,
  output logic             any_o
);

  logic [NREQ-1:0] rot;
  int              first;
  int              idx;

  always_comb begin
    rot   = '0;
    first = 0;
    idx   = 0;
    any_o = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int m = 0; m < NREQ; m++) begin
        if (m == (k + int'(ptr_i)) % NREQ) begin
          rot[k] = pend_i[m];
        end
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!any_o && rot[k]) begin
        any_o = 1'b1;
        first = k;
      end
    end
    idx       = (first + int'(ptr_i)) % NREQ;
    win_idx_o = PTR_W'(idx);
    win_oh_o  = '0;
    for (int m = 0; m < NREQ; m++) begin
      win_oh_o[m] = any_o && (m == idx);
    end
  end

endmodule

// File: rtl/count_arbiter.sv
// Shared up/down counter served round-robin
// from latched per-requester inc/dec pulses.
module count_arbiter
  import count_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_inc,
  input  logic [NREQ-1:0]  req_dec,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic [NREQ-1:0]  gnt,
  output logic             gnt_vld,
  output logic             wrap,
  output logic [NREQ-1:0]  pend,
  output logic [NREQ-1:0]  ovr
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [NREQ-1:0]  pend_q, pend_d;
  logic [NREQ-1:0]  op_q, op_d;
  logic [NREQ-1:0]  ovr_q, ovr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic             wrap_q, wrap_d;

  logic [NREQ-1:0]  win_oh;
  logic [PTR_W-1:0] win_idx;
  logic             any;
  logic             win_op;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .pend_i    (pend_q),
    .ptr_i     (ptr_q),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx),
    .any_o     (any)
  );

  always_comb begin
    pend_d    = pend_q;
    op_d      = op_q;
    ovr_d     = ovr_q;
    q_d       = q_q;
    ptr_d     = ptr_q;
    gnt_d     = '0;
    gnt_vld_d = 1'b0;
    wrap_d    = 1'b0;
    win_op    = |(win_oh & op_q);
    if (any) begin
      pend_d    = pend_q & ~win_oh;
      ptr_d     = ptr_inc(win_idx, NREQ);
      gnt_d     = win_oh;
      gnt_vld_d = 1'b1;
    end
    // a slot frees up on the same edge its owner is granted
    for (int i = 0; i < NREQ; i++) begin
      if (req_inc[i] ^ req_dec[i]) begin
        if (!pend_q[i] || win_oh[i]) begin
          pend_d[i] = 1'b1;
          op_d[i]   = req_dec[i];
        end else begin
          ovr_d[i] = 1'b1;
        end
      end
    end
    if (clr) begin
      q_d = '0;
    end else if (any) begin
      if (win_op == OP_DEC) begin
        wrap_d = (q_q == '0);
        q_d    = q_q - ONE;
      end else begin
        wrap_d = &q_q;
        q_d    = q_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q       <= '0;
      pend_q    <= '0;
      op_q      <= '0;
      ovr_q     <= '0;
      ptr_q     <= '0;
      gnt_q     <= '0;
      gnt_vld_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      q_q       <= q_d;
      pend_q    <= pend_d;
      op_q      <= op_d;
      ovr_q     <= ovr_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_vld_q <= gnt_vld_d;
      wrap_q    <= wrap_d;
    end
  end

  assign q       = q_q;
  assign gnt     = gnt_q;
  assign gnt_vld = gnt_vld_q;
  assign wrap    = wrap_q;
  assign pend    = pend_q;
  assign ovr     = ovr_q;

endmodule

// File: tb/tb_count_arbiter.sv
// Directed plus random stimulus for count_arbiter,
// checked every cycle against a queue-style reference model.
module tb_count_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] req_inc = '0;
  logic [N-1:0] req_dec = '0;
  logic         clr = 1'b0;
  logic [W-1:0] q;
  logic [N-1:0] gnt;
  logic         gnt_vld;
  logic         wrap;
  logic [N-1:0] pend;
  logic [N-1:0] ovr;

  int checks = 0;
  int errors = 0;

  // reference state
  bit         m_pend [N];
  bit         m_dec  [N];
  bit         m_ovr  [N];
  int         m_ptr;
  int         m_win;
  longint     m_cnt;
  bit         m_wrap;

  count_arbiter #(.NREQ(N), .WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_inc (req_inc),
    .req_dec (req_dec),
    .clr     (clr),
    .q       (q),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .wrap    (wrap),
    .pend    (pend),
    .ovr     (ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [N-1:0] inc, input logic [N-1:0] dec,
                       input logic c, input logic r);
    bit old_pend [N];
    bit old_dec  [N];
    int w;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_dec[i] = 0; m_ovr[i] = 0;
      end
      m_ptr = 0; m_win = -1; m_cnt = 0; m_wrap = 0;
      return;
    end
    old_pend = m_pend;
    old_dec  = m_dec;
    w = -1;
    for (int k = 0; k < N; k++) begin
      int j = (m_ptr + k) % N;
      if (w < 0 && old_pend[j]) w = j;
    end
    if (w >= 0) begin
      m_pend[w] = 0;
      m_ptr = (w + 1) % N;
    end
    m_win = w;
    for (int i = 0; i < N; i++) begin
      if (inc[i] != dec[i]) begin
        if (!old_pend[i] || w == i) begin
          m_pend[i] = 1;
          m_dec[i]  = dec[i];
        end else begin
          m_ovr[i] = 1;
        end
      end
    end
    m_wrap = 0;
    if (c) begin
      m_cnt = 0;
    end else if (w >= 0) begin
      m_cnt = old_dec[w] ? m_cnt - 1 : m_cnt + 1;
      if (m_cnt < 0) begin
        m_cnt += 64'd1 << W; m_wrap = 1;
      end else if (m_cnt >= (64'd1 << W)) begin
        m_cnt -= 64'd1 << W; m_wrap = 1;
      end
    end
  endtask

  task automatic compare();
    logic [N-1:0] e_pend, e_ovr, e_gnt;
    for (int i = 0; i < N; i++) begin
      e_pend[i] = m_pend[i];
      e_ovr[i]  = m_ovr[i];
      e_gnt[i]  = (m_win == i);
    end
    chk("q",       q,             W'(m_cnt));
    chk("gnt",     W'(gnt),       W'(e_gnt));
    chk("gnt_vld", W'(gnt_vld),   W'(m_win >= 0));
    chk("wrap",    W'(wrap),      W'(m_wrap));
    chk("pend",    W'(pend),      W'(e_pend));
    chk("ovr",     W'(ovr),       W'(e_ovr));
  endtask

  task automatic step(input logic [N-1:0] inc, input logic [N-1:0] dec,
                      input logic c, input logic r);
    req_inc = inc;
    req_dec = dec;
    clr     = c;
    rst     = r;
    @(posedge clk);
    model(inc, dec, c, r);
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    // reset then single pulse
    step('0, '0, 0, 1);
    step('0, '0, 0, 1);
    step(4'b0001, '0, 0, 0);
    idle(2);
    // round robin from ptr=0
    step('0, '0, 0, 1);
    step(4'b1111, '0, 0, 0);
    idle(5);
    // move ptr to 2, then pend 0101 (inc)
    step(4'b0010, '0, 0, 0);
    idle(1);
    step(4'b0101, '0, 0, 0);
    idle(3);
    // ptr back to 2, inc on 2 and dec on 0
    step(4'b0010, '0, 0, 0);
    idle(2);
    step(4'b0100, 4'b0001, 0, 0);
    idle(3);
    // wrap in both directions
    step('0, '0, 0, 1);
    step('0, 4'b0001, 0, 0);
    idle(1);
    step(4'b0001, '0, 0, 0);
    idle(1);
    step('0, 4'b0001, 0, 0);
    idle(2);
    // lost request on 3, then a collision on 1
    step('0, '0, 0, 1);
    step(4'b1111, '0, 0, 0);
    step(4'b1000, '0, 0, 0);
    idle(4);
    step(4'b0010, 4'b0010, 0, 0);
    idle(2);
    // clr on a grant to requester 1 at q=7
    step('0, '0, 0, 1);
    for (int k = 0; k < 7; k++) begin
      step(4'b0010, '0, 0, 0);
      idle(1);
    end
    step(4'b0010, '0, 0, 0);
    step('0, '0, 1, 0);
    idle(1);
    // reset while pend=0110
    step(4'b0110, '0, 0, 0);
    step('0, '0, 0, 1);
    idle(1);
    // random traffic
    for (int k = 0; k < 600; k++) begin
      step(N'($urandom & $urandom), N'($urandom & $urandom),
           ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 127) == 0));
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
